// File: rtl/div_pkg.sv
// Shared types and constants for the division sequencer: FSM state encoding,
// the default iteration count and the iteration-counter width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } div_state_t;

    localparam int DIV_ITERATIONS = 32;

    // The counter must be able to hold the value ITERATIONS itself.
    function automatic int cnt_width(input int iterations);
        return $clog2(iterations + 1);
    endfunction

    localparam int DIV_CNT_W = $clog2(DIV_ITERATIONS + 1);

endpackage

// File: rtl/div_seq_if.sv
// Bus between the control unit / iterative divider and div_seq. The master
// modport is the environment side; the slave modport is the sequencer.
interface div_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        div_op;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, a, b, div_q, div_r, hi_we, lo_we, wdata,
        input  div_op, div_dividend, div_divisor, busy, done, div0, hi, lo
    );

    modport slave (
        input  start, a, b, div_q, div_r, hi_we, lo_we, wdata,
        output div_op, div_dividend, div_divisor, busy, done, div0, hi, lo
    );
endinterface

// File: rtl/div_sign_fix.sv
// Signed-mode helper: converts operands to magnitudes and restores result
// signs. Purely combinational; only instantiated when DIV_SIGNED_EN is set.
module div_sign_fix (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] q_raw,
    input  logic [31:0] r_raw,
    input  logic        neg_q,
    input  logic        neg_r,
    output logic [31:0] a_mag,
    output logic [31:0] b_mag,
    output logic [31:0] q_fix,
    output logic [31:0] r_fix
);
    // 0x80000000 has no positive counterpart; its two's complement is itself,
    // which is the correct unsigned magnitude for the divider.
    assign a_mag = a[31] ? (~a + 32'd1) : a;
    assign b_mag = b[31] ? (~b + 32'd1) : b;

    assign q_fix = neg_q ? (~q_raw + 32'd1) : q_raw;
    assign r_fix = neg_r ? (~r_raw + 32'd1) : r_raw;
endmodule

// File: rtl/div_seq.sv
// Division sequencer with HI/LO registers. Unsigned (divu) by default;
// define DIV_SIGNED_EN to add magnitude conversion and signed result fix-up.
module div_seq
    import div_pkg::*;
#(
    parameter int ITERATIONS = DIV_ITERATIONS
) (
    input logic       clk,
    input logic       reset,
    div_seq_if.slave  bus
);
    localparam int               CNT_W = cnt_width(ITERATIONS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITERATIONS - 1);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept, div0_req, commit, active;
    logic [31:0]      a_in, b_in, q_fix, r_fix;

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;

    div_sign_fix u_sign_fix (
        .a     (bus.a),
        .b     (bus.b),
        .q_raw (bus.div_q),
        .r_raw (bus.div_r),
        .neg_q (neg_q),
        .neg_r (neg_r),
        .a_mag (a_in),
        .b_mag (b_in),
        .q_fix (q_fix),
        .r_fix (r_fix)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= bus.a[31] ^ bus.b[31];
            neg_r <= bus.a[31];
        end
    end
`else
    assign a_in  = bus.a;
    assign b_in  = bus.b;
    assign q_fix = bus.div_q;
    assign r_fix = bus.div_r;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held and infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        div0_req   = 1'b0;
        commit     = 1'b0;
        active     = (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.b == 32'd0) begin
                        div0_req = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == LAST) state_next = CAPTURE;
            end
            CAPTURE: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.div_op = active;
    assign bus.busy   = active;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.div_dividend <= '0;
            bus.div_divisor  <= '0;
            bus.done         <= 1'b0;
            bus.div0         <= 1'b0;
        end else begin
            state    <= state_next;
            bus.done <= commit;
            bus.div0 <= div0_req;
            if (accept) begin
                cnt              <= '0;
                bus.div_dividend <= a_in;
                bus.div_divisor  <= b_in;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // The result commit takes priority over a direct mthi/mtlo on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.hi <= '0;
            bus.lo <= '0;
        end else begin
            if (commit)         bus.hi <= r_fix;
            else if (bus.hi_we) bus.hi <= bus.wdata;
            if (commit)         bus.lo <= q_fix;
            else if (bus.lo_we) bus.lo <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: behavioural divider, scoreboard of expected
// HI/LO results, vector table plus hand-written corner-case sequences.
module tb_div_seq;
    import div_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_seq_if bus ();

    div_seq #(.ITERATIONS(DIV_ITERATIONS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural iterative divider: cleared while div_op is low, result
    // appears after ITERATIONS clocked cycles with div_op high, then holds.
    logic [7:0] mcnt;
    always @(posedge clk) begin
        if (!bus.div_op) begin
            mcnt      <= '0;
            bus.div_q <= '0;
            bus.div_r <= '0;
        end else begin
            mcnt <= mcnt + 8'd1;
            if (mcnt == 8'(DIV_ITERATIONS - 1)) begin
                bus.div_q <= bus.div_dividend / bus.div_divisor;
                bus.div_r <= bus.div_dividend % bus.div_divisor;
            end
        end
    end

    // Scoreboard: every done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            check("sb_expecting", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("sb_lo", bus.lo, mon_e.q);
                check("sb_hi", bus.hi, mon_e.r);
            end
        end
    end

    // One division from the start cycle (cycle 0) through cycle 34. With chain
    // set, start is raised in the current cycle (back-to-back issue).
    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input bit chain,
                          input int s1, input int s2, input int we_cyc);
        int op_cnt, done_cyc, dones;
        if (!chain) @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sb.push_back('{q: q, r: r});
        op_cnt   = 0;
        done_cyc = 0;
        dones    = 0;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clk);
            if (bus.div_op) op_cnt++;
            if (bus.done) begin
                dones++;
                if (done_cyc == 0) done_cyc = cyc;
                check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
            end
            bus.start = (cyc == s1 || cyc == s2);
            bus.hi_we = (cyc == we_cyc);
            if (bus.start) begin
                bus.a = 32'd1000;
                bus.b = 32'd3;
            end
        end
        check({name, "_done_cycle"}, 32'(done_cyc), 32'd34);
        check({name, "_div_op_cycles"}, 32'(op_cnt), 32'(DIV_ITERATIONS + 1));
        check({name, "_done_count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DIV_SIGNED_EN
        vecs[0] = '{32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        vecs[2] = '{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vecs[3] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
        vecs[4] = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE};
        vecs[5] = '{32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0};
`else
        vecs[0] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[2] = '{32'd5,         32'd9,         32'd0,         32'd5};
        vecs[3] = '{32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 32'd2};
        vecs[4] = '{32'hDEAD_BEEF, 32'h10,        32'h0DEA_DBEE, 32'hF};
        vecs[5] = '{32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1};
`endif
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_div_op", 32'(bus.div_op), 32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_div0",   32'(bus.div0),   32'd0);
        check("rst_hi",     bus.hi,          32'd0);
        check("rst_lo",     bus.lo,          32'd0);
        reset = 1'b0;

        do_div("u100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, 0, 0);
        check("u100_7_lo", bus.lo, 32'd14);
        check("u100_7_hi", bus.hi, 32'd2);

        // Table entries are issued back-to-back: each start lands in the
        // done cycle of the previous division.
        for (int i = 0; i < 6; i++)
            do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   (i != 0), 0, 0, 0);
        bus.start = 1'b0;

        // Divide by zero with HI/LO preloaded.
        @(negedge clk);
        bus.wdata = 32'h11;
        bus.hi_we = 1'b1;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.wdata = 32'h22;
        bus.lo_we = 1'b1;
        @(negedge clk);
        bus.lo_we = 1'b0;
        bus.a     = 32'd1234;
        bus.b     = 32'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("div0_pulse", 32'(bus.div0),   32'd1);
        check("div0_busy",  32'(bus.busy),   32'd0);
        check("div0_op",    32'(bus.div_op), 32'd0);
        @(negedge clk);
        check("div0_end",   32'(bus.div0),   32'd0);
        check("div0_busy2", 32'(bus.busy),   32'd0);
        check("div0_hi",    bus.hi,          32'h11);
        check("div0_lo",    bus.lo,          32'h22);

        // Reset in cycle 15 of a division.
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("midrst_div_op", 32'(bus.div_op), 32'd0);
        check("midrst_busy",   32'(bus.busy),   32'd0);
        check("midrst_hi",     bus.hi,          32'd0);
        check("midrst_lo",     bus.lo,          32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("midrst_no_done", 32'(sb.size()), 32'd0);

        do_div("post_rst_9_4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 0, 0, 0);

        // mthi in the CAPTURE cycle loses to the commit; mtlo in IDLE lands.
        bus.wdata = 32'h0000_ABCD;
        do_div("cap_we_9_4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 0, 0, 33);
        check("cap_we_hi", bus.hi, 32'd1);
        bus.wdata = 32'h55;
        bus.lo_we = 1'b1;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo_lo", bus.lo, 32'h55);
        check("mtlo_hi", bus.hi, 32'd1);

        // Start re-asserted in cycles 5 and 20 must be ignored.
        do_div("ignore_50_5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 5, 20, 0);
        repeat (40) @(negedge clk);
        check("ignore_idle", 32'(bus.busy), 32'd0);
        check("sb_drained",  32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_seq.md
# div_seq

Division sequencer and HI/LO register pair, sitting between the control unit and the 32-bit iterative divider. It takes a one-cycle start request with operands rs/rt, holds the divider's `divOp` high for exactly the right number of cycles, and applies the optional signed fix-up. It then commits quotient to LO and remainder to HI and signals completion or divide-by-zero to the control unit.

## Interface
- `ITERATIONS`, default 32: divider iteration cycles; must equal the operand width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request a division; sampled only in IDLE.
- `a` in 32: dividend (rs).
- `b` in 32: divisor (rt).
- `div_op` out 1: drives the divider's `divOp`.
- `div_dividend` out 32: drives the divider's `dividend`; registered.
- `div_divisor` out 32: drives the divider's `divisor`; registered.
- `div_q` in 32: the divider's quotient output (`div_hi`).
- `div_r` in 32: the divider's remainder output (`div_lo`).
- `hi_we` in 1: direct HI write (mthi).
- `lo_we` in 1: direct LO write (mtlo).
- `wdata` in 32: data for `hi_we` / `lo_we`.
- `busy` out 1: high in RUN and CAPTURE.
- `done` out 1: one-cycle pulse after HI/LO commit.
- `div0` out 1: one-cycle pulse when `start` is accepted with `b == 0`.
- `hi` out 32: HI register (remainder).
- `lo` out 32: LO register (quotient).

## Operation
- Reset values: all outputs 0; state IDLE.
- States:
  - **IDLE**: `div_op`=0. On `start`:
    - If `b == 0`: stay in IDLE, pulse `div0` next cycle, leave HI/LO unchanged.
    - Otherwise: register operands (magnitudes in signed mode), latch sign bits, go to RUN with counter = 0.
  - **RUN**: `div_op`=1; counter increments each cycle. After `ITERATIONS` cycles, go to CAPTURE.
  - **CAPTURE**: `div_op`=1. The divider is idle and its outputs are stable during this cycle. At the closing edge:
    - LO ← fixed quotient, HI ← fixed remainder.
    - `done` ← 1 for one cycle.
    - Next state IDLE. `div_op` falls, which clears the divider.
- `start` while busy: ignored, with no queuing.
- `hi_we` / `lo_we`: accepted in any state. When one collides with the CAPTURE commit on the same edge, the commit wins for that register.
- Reset mid-operation: immediate return to IDLE, `div_op`=0, HI/LO cleared, no `done`.
- `div_q` / `div_r` are sampled only in CAPTURE. On that edge the divider's outputs do not change, so there is no sampling race.

## Timing
- Cycle 0: `start` high, sampled at edge 1.
- Cycles 1..32: RUN, `busy`=1, `div_op`=1.
- Cycle 33: CAPTURE, `busy`=1.
- Edge 34: HI/LO update. `done`=1 during cycle 34; `busy`=0.
- Back-to-back: a new `start` is accepted in cycle 34.
- `div_op` is high for exactly `ITERATIONS`+1 consecutive cycles per division.
- `div0`: high in cycle 1 only; `busy` never rises.

## Configuration
- `DIV_SIGNED_EN` defined:
  - Operands are converted to magnitudes before the divider.
  - Quotient is negated when `a[31]^b[31]`; remainder takes the sign of `a`.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- `DIV_SIGNED_EN` undefined: unsigned (divu) only. Operands are passed raw, results are committed unmodified, and the fix-up logic is absent.

## Structure
- Package `div_pkg` holds:
  - the state enum (IDLE, RUN, CAPTURE);
  - `DIV_ITERATIONS` = 32;
  - the counter width constant (`$clog2(ITERATIONS+1)`).
- One combinational sub-module, `div_sign_fix`:
  - operand magnitudes;
  - result sign correction;
  - instantiated only under `DIV_SIGNED_EN`.

## Test plan
- Unsigned 100 / 7: `done` in cycle 34, LO=14, HI=2, `div_op` high for 33 cycles.
- Signed (`DIV_SIGNED_EN`) -7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF; also 0x80000000 / -1 gives LO=0x80000000, HI=0.
- `b` = 0 with HI/LO preloaded to 0x11/0x22: `div0` pulses in cycle 1, `busy` stays 0, HI/LO unchanged.
- `start` re-asserted in cycles 5 and 20 during a division of 50 / 5: ignored, one `done` only, LO=10, HI=0.
- `reset` in cycle 15: `div_op`, `busy`, HI and LO all 0 immediately; a following 9 / 4 yields LO=2, HI=1.
- `hi_we` with 0xABCD in the CAPTURE cycle of 9 / 4: HI=1 (commit wins); `lo_we` in IDLE with 0x55 gives LO=0x55 next cycle.
